// File: rtl/mips_pkg.sv
// Shared MIPS definitions: bubble encoding, opcodes, and the fetch FSM state
// encoding, plus the record type that moves through the skid buffer and IF/ID.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } fetch_word_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory read port: the fetch stage is the master, memory the slave.
interface instruction_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ready, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_next_pc.sv
// Target adders and redirect priority (branch > jump > sequential).
// Purely combinational; the result is always word-aligned.
module fetch_next_pc (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc_plus4,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic        if_id_valid,
  input  logic        stall,
  input  logic [3:0]  jump_pc_hi,
  input  logic [25:0] jump_index,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic [31:0] w_branch_target;
  logic [31:0] w_jump_target;
  logic [31:0] w_seq_pc;
  logic [31:0] w_sel_pc;

  assign w_branch_target = branch_pc_plus4 + (branch_offset << 2);
  assign w_jump_target   = {jump_pc_hi, jump_index, 2'b00};
  assign w_seq_pc        = pc + 32'd4;

  // NOTE: every output gets a default first so no path through the if-chain
  // leaves a variable unassigned and infers a latch.
  always_comb begin
    redirect = 1'b0;
    w_sel_pc = w_seq_pc;
    if (branch_taken) begin
      redirect = 1'b1;
      w_sel_pc = w_branch_target;
    end else if (jump && if_id_valid && !stall) begin
      redirect = 1'b1;
      w_sel_pc = w_jump_target;
    end
  end

  assign next_pc = {w_sel_pc[31:2], 2'b00};

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC, fetch FSM, one-entry skid buffer and the IF/ID register.
// Bubbles are the all-zero instruction with if_id_valid low.
module instruction_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  instruction_fetch_stage_if.master   imem,
  input  logic                        stall,
  input  logic                        branch_taken,
  input  logic [31:0]                 branch_pc_plus4,
  input  logic [31:0]                 branch_offset,
  input  logic                        jump,
  output logic                        if_id_valid,
  output logic [31:0]                 if_id_instr,
  output logic [31:0]                 if_id_pc_plus4
);

  fetch_state_e r_state, w_state_next;
  logic [31:0]  r_pc, w_pc_next;
  logic [31:0]  r_discard_addr, w_discard_addr_next;
  fetch_word_t  r_skid, w_skid_next;
  fetch_word_t  r_if_id, w_if_id_next;
  logic         r_if_id_valid, w_if_id_valid_next;

  logic [31:0]  w_next_pc;
  logic         w_redirect;

  fetch_next_pc u_next_pc (
    .pc              (r_pc),
    .branch_taken    (branch_taken),
    .branch_pc_plus4 (branch_pc_plus4),
    .branch_offset   (branch_offset),
    .jump            (jump),
    .if_id_valid     (r_if_id_valid),
    .stall           (stall),
    .jump_pc_hi      (r_if_id.pc_plus4[31:28]),
    .jump_index      (r_if_id.instr[25:0]),
    .next_pc         (w_next_pc),
    .redirect        (w_redirect)
  );

  // In DISCARD the old request is still outstanding, so its address is
  // replayed until memory answers even though the PC has already moved on.
  assign imem.imem_req  = reset_n && (r_state != HOLD);
  assign imem.imem_addr = (r_state == DISCARD) ? r_discard_addr : r_pc;

  assign if_id_valid    = r_if_id_valid;
  assign if_id_instr    = r_if_id.instr;
  assign if_id_pc_plus4 = r_if_id.pc_plus4;

  always_comb begin
    w_state_next        = r_state;
    w_pc_next           = r_pc;
    w_discard_addr_next = r_discard_addr;
    w_skid_next         = r_skid;
    w_if_id_next        = r_if_id;
    w_if_id_valid_next  = r_if_id_valid;

    if (w_redirect) begin
      w_pc_next          = w_next_pc;
      w_if_id_valid_next = 1'b0;
      w_if_id_next.instr = NOP_INSTR;
      w_skid_next        = '0;
      if (r_state != HOLD && !imem.imem_ready) begin
        w_state_next = DISCARD;
        if (r_state == FETCH) w_discard_addr_next = r_pc;
      end else begin
        w_state_next = FETCH;
      end
    end else begin
      unique case (r_state)
        FETCH: begin
          if (imem.imem_ready) begin
            w_pc_next = w_next_pc;
            if (stall) begin
              w_skid_next  = '{instr: imem.imem_rdata, pc_plus4: w_next_pc};
              w_state_next = HOLD;
            end else begin
              w_if_id_valid_next = 1'b1;
              w_if_id_next       = '{instr: imem.imem_rdata, pc_plus4: w_next_pc};
            end
          end else if (!stall) begin
            // Decode consumed IF/ID and nothing arrived: present a bubble.
            w_if_id_valid_next = 1'b0;
            w_if_id_next.instr = NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall) begin
            w_if_id_valid_next = 1'b1;
            w_if_id_next       = r_skid;
            w_skid_next        = '0;
            w_state_next       = FETCH;
          end
        end
        DISCARD: begin
          if (imem.imem_ready) w_state_next = FETCH;
        end
        default: w_state_next = FETCH;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= FETCH;
      r_pc           <= RESET_PC;
      r_discard_addr <= '0;
      r_skid         <= '0;
      r_if_id        <= '0;
      r_if_id_valid  <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_discard_addr <= w_discard_addr_next;
      r_skid         <= w_skid_next;
      r_if_id        <= w_if_id_next;
      r_if_id_valid  <= w_if_id_valid_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: a cycle table for zero-wait
// memory, then hand sequences for slow memory, DISCARD and mid-fetch reset.
module tb_instruction_fetch_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, branch_taken, jump, jump_en;
  logic [31:0] branch_pc_plus4, branch_offset;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc_plus4;

  int n_tests = 0;
  int n_fail  = 0;
  int latency = 0;
  int wait_cnt = 0;

  instruction_fetch_stage_if imem_bus ();

  instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem            (imem_bus.master),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_pc_plus4 (branch_pc_plus4),
    .branch_offset   (branch_offset),
    .jump            (jump),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus4  (if_id_pc_plus4)
  );

  always #5 clk = ~clk;

  // Memory contents: addi at 0, a J at 0x2000_0000, otherwise a word tagged
  // with its own low address bits so any lost or repeated fetch is visible.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000)      return 32'h2008_0005;
    else if (a == 32'h2000_0000) return 32'h0800_0040;
    else                         return {16'h2009, a[15:0]};
  endfunction

  assign imem_bus.imem_ready = imem_bus.imem_req && (wait_cnt >= latency);
  assign imem_bus.imem_rdata = imem_bus.imem_ready ? mem_word(imem_bus.imem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!imem_bus.imem_req || imem_bus.imem_ready) wait_cnt <= 0;
    else                                           wait_cnt <= wait_cnt + 1;
  end

  // Control-unit model: jump decoded from the opcode in IF/ID.
  assign jump = jump_en && (if_id_instr[31:26] == OP_J);

  typedef struct packed {
    logic        stall;
    logic        br;
    logic [31:0] bpc4;
    logic [31:0] boff;
    logic        jen;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bp,
                              input logic [31:0] bo, input logic j, input logic rq,
                              input logic [31:0] ad, input logic vl,
                              input logic [31:0] ins, input logic [31:0] p4);
    vec_t v;
    v = '{stall: s, br: b, bpc4: bp, boff: bo, jen: j, exp_req: rq, exp_addr: ad,
          exp_valid: vl, exp_instr: ins, exp_pc4: p4};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic rq, input logic [31:0] ad,
                           input logic vl, input logic [31:0] ins, input logic [31:0] p4);
    check({tag, " req"}, {31'd0, imem_bus.imem_req}, {31'd0, rq});
    if (rq) check({tag, " addr"}, imem_bus.imem_addr, ad);
    check({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, vl});
    check({tag, " instr"}, if_id_instr, ins);
    if (vl) check({tag, " pc4"}, if_id_pc_plus4, p4);
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] bp,
                       input logic [31:0] bo, input logic j);
    stall = s; branch_taken = b; branch_pc_plus4 = bp; branch_offset = bo; jump_en = j;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Zero-wait stream, 3-cycle stall, branch, jump, branch+jump, branch in
    // HOLD, sequential wrap, dropped adder carry, jump held off by stall.
    vecs.push_back(mk(0,0,0,0,0, 1,32'h4,        1,32'h2008_0005,32'h4));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h8,        1,32'h2009_0004,32'h8));
    vecs.push_back(mk(1,0,0,0,0, 0,0,            1,32'h2009_0004,32'h8));
    vecs.push_back(mk(1,0,0,0,0, 0,0,            1,32'h2009_0004,32'h8));
    vecs.push_back(mk(1,0,0,0,0, 0,0,            1,32'h2009_0004,32'h8));
    vecs.push_back(mk(0,0,0,0,0, 1,32'hC,        1,32'h2009_0008,32'hC));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h10,       1,32'h2009_000C,32'h10));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h14,       1,32'h2009_0010,32'h14));
    vecs.push_back(mk(0,1,32'h10,32'hFFFF_FFFE,0, 1,32'h8, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'hC,        1,32'h2009_0008,32'hC));
    vecs.push_back(mk(0,1,32'h1FFF_FFF0,32'h4,0, 1,32'h2000_0000, 0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h2000_0004, 1,32'h0800_0040,32'h2000_0004));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h2000_0100, 0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h2000_0104, 1,32'h2009_0100,32'h2000_0104));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h2000_0108, 1,32'h2009_0104,32'h2000_0108));
    vecs.push_back(mk(0,1,32'h1FFF_FFF0,32'h4,0, 1,32'h2000_0000, 0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h2000_0004, 1,32'h0800_0040,32'h2000_0004));
    vecs.push_back(mk(0,1,32'h40,32'h10,1, 1,32'h80, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h84,       1,32'h2009_0080,32'h84));
    vecs.push_back(mk(1,0,0,0,0, 0,0,            1,32'h2009_0080,32'h84));
    vecs.push_back(mk(1,1,32'h100,32'h0,0, 1,32'h100, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h104,      1,32'h2009_0100,32'h104));
    vecs.push_back(mk(0,1,32'hFFFF_FFF8,32'h1,0, 1,32'hFFFF_FFFC, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h0,        1,32'h2009_FFFC,32'h0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h4,        1,32'h2008_0005,32'h4));
    vecs.push_back(mk(0,1,32'hFFFF_FFF0,32'h8,0, 1,32'h10, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h14,       1,32'h2009_0010,32'h14));
    vecs.push_back(mk(0,1,32'h1FFF_FFF0,32'h4,0, 1,32'h2000_0000, 0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h2000_0004, 1,32'h0800_0040,32'h2000_0004));
    vecs.push_back(mk(1,0,0,0,1, 0,0,            1,32'h0800_0040,32'h2000_0004));
    vecs.push_back(mk(0,0,0,0,1, 1,32'h2000_0100, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 1,32'h2000_0104, 1,32'h2009_0100,32'h2000_0104));

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check_out("reset", 0, 0, 0, 32'h0, 32'h0);
    check("reset pc4", if_id_pc_plus4, 32'h0);
    reset_n = 1'b1;
    #1;
    check_out("release", 1, 32'h0, 0, 32'h0, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].bpc4, vecs[i].boff, vecs[i].jen);
      tick();
      check_out($sformatf("v%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                vecs[i].exp_valid, vecs[i].exp_instr, vecs[i].exp_pc4);
    end

    // Slow memory: redirect while a request is pending, then a second redirect
    // inside DISCARD; the stale response must be dropped.
    latency = 3;
    drive(0, 1, 32'h200, 32'h0, 0);
    tick();
    check_out("disc0", 1, 32'h2000_0104, 0, 32'h0, 32'h0);
    drive(0, 1, 32'h300, 32'h0, 0);
    tick();
    check_out("disc1", 1, 32'h2000_0104, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0);
    tick();
    check_out("disc2", 1, 32'h2000_0104, 0, 32'h0, 32'h0);
    tick();
    check_out("disc_done", 1, 32'h300, 0, 32'h0, 32'h0);

    // Stall with no response pending: request stays up at the same address.
    drive(1, 0, 0, 0, 0);
    tick();
    check_out("wstall0", 1, 32'h300, 0, 32'h0, 32'h0);
    tick();
    check_out("wstall1", 1, 32'h300, 0, 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0);
    tick();
    check_out("wait", 1, 32'h300, 0, 32'h0, 32'h0);
    tick();
    check_out("slow_fetch", 1, 32'h304, 1, 32'h2009_0300, 32'h304);

    // Asynchronous reset with IF/ID full and a request outstanding.
    #2;
    reset_n = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 32'h0, 32'h0);
    check("async_rst pc4", if_id_pc_plus4, 32'h0);
    latency = 0;
    #1;
    reset_n = 1'b1;
    #1;
    check_out("rst_release", 1, 32'h0, 0, 32'h0, 32'h0);
    tick();
    check_out("rst_fetch", 1, 32'h4, 1, 32'h2008_0005, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
